// File: rtl/mux_nto1_rr.sv
// N-to-1 valid/ready multiplexer with a one-entry registered output, fixed-select or round-robin grant.
// Define MUX_NTO1_CNT_EN to add the 16-bit xfer_cnt output-transfer counter.
module mux_nto1_rr #(
  parameter int W = 8,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] s,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SELW-1:0] y_sel
`ifdef MUX_NTO1_CNT_EN
  ,
  output logic [15:0]     xfer_cnt
`endif
);

  logic            load;
  logic            grant;
  logic [SELW-1:0] g;
  logic [SELW-1:0] ptr;
  int unsigned     idx;

  assign load = !y_valid || y_ready;

  // Round-robin scans from ptr upward with wrap; first valid channel wins.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    idx   = 0;
    if (!mode) begin
      if (int'(s) < N && in_valid[s]) begin
        grant = 1'b1;
        g     = s;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = (int'(ptr) + i) % N;
        if (!grant && in_valid[idx[SELW-1:0]]) begin
          grant = 1'b1;
          g     = idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load && grant) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_sel   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (grant) begin
        y       <= in_data[g*W +: W];
        y_sel   <= g;
        y_valid <= 1'b1;
        ptr     <= (g == SELW'(N-1)) ? '0 : g + 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_NTO1_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else if (y_valid && y_ready) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed self-checking bench for mux_nto1_rr (N=4, W=8); counter checks only with MUX_NTO1_CNT_EN.
module tb_mux_nto1_rr;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [1:0]     s;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [1:0]     y_sel;
`ifdef MUX_NTO1_CNT_EN
  logic [15:0]    xfer_cnt;
`endif

  int total = 0;
  int bad = 0;

  mux_nto1_rr #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .s(s), .y(y), .y_valid(y_valid),
    .y_ready(y_ready), .y_sel(y_sel)
`ifdef MUX_NTO1_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rr_data;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 4'b1111; mode = 1'b0; s = 2'd2; y_ready = 1'b1;
    in_data = '0;
    in_data[2*W +: W] = 8'hA5;
    tick; tick;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
    total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y); end
`ifdef MUX_NTO1_CNT_EN
    total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", xfer_cnt); end
`endif
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    tick;
    total++; if (y !== 8'hA5) begin bad++; $display("FAIL fixed_y got=%h exp=a5", y); end
    total++; if (y_sel !== 2'd2) begin bad++; $display("FAIL fixed_y_sel got=%0d exp=2", y_sel); end
    total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL fixed_y_valid got=%b exp=1", y_valid); end
  endtask

  task automatic test_idle_select;
    s = 2'd1; in_valid = 4'b1101;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL idle_in_ready got=%b exp=0000", in_ready); end
    tick;
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL idle_y_valid got=%b exp=0", y_valid); end
    total++; if (y !== 8'hA5 || y_sel !== 2'd2) begin bad++; $display("FAIL idle_hold got=%h/%0d exp=a5/2", y, y_sel); end
  endtask

  task automatic test_round_robin;
    rst = 1'b1; tick; rst = 1'b0;
    set_rr_data;
    mode = 1'b1; in_valid = 4'b1111; y_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'(1 << (k % 4)));
      end
      tick;
      total++;
      if (y !== 8'h10 + 8'(k % 4) || y_sel !== 2'(k % 4) || y_valid !== 1'b1) begin
        bad++; $display("FAIL rr_out[%0d] got=%h/%0d/%b exp=%h/%0d/1", k, y, y_sel, y_valid, 8'h10 + 8'(k % 4), k % 4);
      end
    end
  endtask

  task automatic test_skip_wrap;
    int exp_sel [3] = '{3, 0, 3};
    mode = 1'b0; s = 2'd0; in_valid = 4'b0001;
    tick;
    mode = 1'b1; in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 4'(1 << exp_sel[k])) begin
        bad++; $display("FAIL skip_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'(1 << exp_sel[k]));
      end
      tick;
      total++;
      if (y_sel !== 2'(exp_sel[k]) || y !== 8'h10 + 8'(exp_sel[k])) begin
        bad++; $display("FAIL skip_out[%0d] got=%0d/%h exp=%0d/%h", k, y_sel, y, exp_sel[k], 8'h10 + 8'(exp_sel[k]));
      end
    end
  endtask

  task automatic test_back_to_back;
    y_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick;
      total++;
      if (y !== 8'h13 || y_sel !== 2'd3 || y_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h/%0d/%b exp=13/3/1", k, y, y_sel, y_valid);
      end
    end
    y_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL b2b_in_ready got=%b exp=0001", in_ready); end
    tick;
    total++;
    if (y !== 8'h10 || y_sel !== 2'd0 || y_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_out got=%h/%0d/%b exp=10/0/1", y, y_sel, y_valid);
    end
  endtask

  task automatic test_reset_mid_stall;
    y_ready = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_stall_in_ready got=%b exp=0000", in_ready); end
    tick;
    total++;
    if (y_valid !== 1'b0 || y !== 8'h00 || y_sel !== 2'd0) begin
      bad++; $display("FAIL rst_stall got=%b/%h/%0d exp=0/00/0", y_valid, y, y_sel);
    end
`ifdef MUX_NTO1_CNT_EN
    total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rst_stall_cnt got=%h exp=0000", xfer_cnt); end
`endif
    rst = 1'b0;
  endtask

`ifdef MUX_NTO1_CNT_EN
  task automatic test_counter;
    rst = 1'b1; tick; rst = 1'b0;
    mode = 1'b1; in_valid = 4'b1111; y_ready = 1'b1;
    repeat (6) tick;
    total++; if (xfer_cnt !== 16'd5) begin bad++; $display("FAIL cnt_five got=%h exp=0005", xfer_cnt); end
    repeat (65530) tick;
    total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_max got=%h exp=ffff", xfer_cnt); end
    tick;
    total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h exp=0000", xfer_cnt); end
  endtask
`endif

  initial begin
    #1;
    test_reset;
    test_idle_select;
    test_round_robin;
    test_skip_wrap;
    test_back_to_back;
    test_reset_mid_stall;
`ifdef MUX_NTO1_CNT_EN
    test_counter;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
